// File: rtl/e15_prog_loader.sv
// Program loader and instruction store for the E15 core.
// Ports: clk, rst_n, load_start/load_len, nib_valid/nib_data/nib_ready,
//        fetch_addr/fetch_instr, core_run, load_busy.
module e15_prog_loader #(
    parameter int WORDS = 16,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [3:0]    load_len,
    input  logic          nib_valid,
    input  logic [3:0]    nib_data,
    output logic          nib_ready,
    input  logic [3:0]    fetch_addr,
    output logic [IW-1:0] fetch_instr,
    output logic          core_run,
    output logic          load_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    nib_cnt;
    logic [3:0]    addr;
    logic [3:0]    last;
    logic [7:0]    asm_hi;
    logic [IW-1:0] mem [WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            nib_cnt <= 2'd0;
            addr    <= 4'd0;
            last    <= 4'd0;
            asm_hi  <= 8'h00;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE, RUN: begin
                    if (load_start) begin
                        state   <= LOAD;
                        last    <= load_len;
                        addr    <= 4'd0;
                        nib_cnt <= 2'd0;
                        for (int i = 0; i < WORDS; i++) begin
                            mem[i] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (nib_valid) begin
                        unique case (nib_cnt)
                            2'd0: begin
                                asm_hi[7:4] <= nib_data;
                                nib_cnt     <= 2'd1;
                            end
                            2'd1: begin
                                asm_hi[3:0] <= nib_data;
                                nib_cnt     <= 2'd2;
                            end
                            default: begin
                                mem[addr] <= {asm_hi, nib_data};
                                addr      <= addr + 4'd1;
                                nib_cnt   <= 2'd0;
                                if (addr == last) begin
                                    state <= RUN;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign nib_ready = (state == LOAD);
    assign load_busy = (state == LOAD);
    assign core_run  = (state == RUN);

    // Outside RUN the core sees "jmp -pc", which walks its pc to 0
    // and then parks there on jmp +0.
    always_comb begin
        if (state == RUN) begin
            fetch_instr = mem[fetch_addr];
        end else begin
            fetch_instr = {8'h00, 4'(~fetch_addr + 4'd1)};
        end
    end

endmodule

// File: tb/tb_e15_prog_loader.sv
// Directed self-checking bench for e15_prog_loader.
// Drives and samples on the falling clock edge.
module tb_e15_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [3:0]  load_len;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_ready;
    logic [3:0]  fetch_addr;
    logic [11:0] fetch_instr;
    logic        core_run;
    logic        load_busy;

    int total = 0;
    int bad   = 0;

    e15_prog_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_len    (load_len),
        .nib_valid   (nib_valid),
        .nib_data    (nib_data),
        .nib_ready   (nib_ready),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .core_run    (core_run),
        .load_busy   (load_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [3:0] d);
        nib_valid = 1'b1;
        nib_data  = d;
        @(negedge clk);
    endtask

    task automatic start(input logic [3:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [3:0] a,
                             input logic [11:0] exp_v);
        fetch_addr = a;
        #1;
        chk(tag, fetch_instr, exp_v);
    endtask

    logic [3:0]  seq [6];
    logic [11:0] acc;
    int          cycles;
    int          k;

    initial begin
        seq[0] = 4'h9; seq[1] = 4'h1; seq[2] = 4'h3;
        seq[3] = 4'hB; seq[4] = 4'h0; seq[5] = 4'h2;
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_len   = 4'd0;
        nib_valid  = 1'b0;
        nib_data   = 4'd0;
        fetch_addr = 4'd0;
        #1;
        chk("rst_ready", {11'd0, nib_ready}, 12'd0);
        chk("rst_run", {11'd0, core_run}, 12'd0);
        chk("rst_busy", {11'd0, load_busy}, 12'd0);
        fetch_chk("park_pc5", 4'd5, 12'h00B);
        fetch_chk("park_pc0", 4'd0, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // load 2 words, nib_valid held high
        start(4'd1);
        chk("l1_busy", {11'd0, load_busy}, 12'd1);
        chk("l1_ready", {11'd0, nib_ready}, 12'd1);
        for (int i = 0; i < 5; i++) send(seq[i]);
        chk("l1_run_before", {11'd0, core_run}, 12'd0);
        send(seq[5]);
        nib_valid = 1'b0;
        chk("l1_run_after", {11'd0, core_run}, 12'd1);
        chk("l1_busy_after", {11'd0, load_busy}, 12'd0);
        fetch_chk("l1_w0", 4'd0, 12'h913);
        fetch_chk("l1_w1", 4'd1, 12'hB02);
        fetch_chk("l1_w7", 4'd7, 12'h000);

        // same load, nib_valid toggling, junk on idle cycles
        @(negedge clk);
        start(4'd1);
        chk("l2_run_drop", {11'd0, core_run}, 12'd0);
        cycles = 0;
        k = 0;
        while (!core_run && cycles < 40) begin
            if (cycles % 2 == 0) begin
                nib_valid = 1'b1;
                nib_data  = (k < 6) ? seq[k] : 4'h0;
                k++;
            end else begin
                nib_valid = 1'b0;
                nib_data  = 4'hF;
            end
            @(negedge clk);
            cycles++;
        end
        nib_valid = 1'b0;
        chk("l2_cycles", 12'(cycles), 12'd11);
        fetch_chk("l2_w0", 4'd0, 12'h913);
        fetch_chk("l2_w1", 4'd1, 12'hB02);
        fetch_chk("l2_w2", 4'd2, 12'h000);

        // full 16-word load
        @(negedge clk);
        start(4'd15);
        for (int i = 0; i < 16; i++) begin
            send(4'(i));
            send(4'(i));
            if (i == 15) chk("l3_run_before", {11'd0, core_run}, 12'd0);
            send(4'(i));
        end
        chk("l3_run_after", {11'd0, core_run}, 12'd1);
        for (int i = 0; i < 3; i++) send(4'hF);
        nib_valid = 1'b0;
        chk("l3_ready_run", {11'd0, nib_ready}, 12'd0);
        for (int i = 0; i < 16; i++) begin
            fetch_chk($sformatf("l3_w%0d", i), 4'(i),
                      {4'(i), 4'(i), 4'(i)});
        end

        // reload with len 0; nibble alongside load_start is dropped
        @(negedge clk);
        nib_valid = 1'b1;
        nib_data  = 4'h7;
        start(4'd0);
        nib_valid = 1'b0;
        chk("r_run_drop", {11'd0, core_run}, 12'd0);
        fetch_chk("r_park_pc3", 4'd3, 12'h00D);
        acc = 12'h000;
        for (int i = 1; i < 16; i++) acc = acc | dut.mem[i];
        chk("r_cleared", acc, 12'h000);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 4'd5;
        send(4'h8);
        load_start = 1'b0;
        send(4'h0);
        send(4'h0);
        nib_valid = 1'b0;
        chk("r_run", {11'd0, core_run}, 12'd1);
        fetch_chk("r_w0", 4'd0, 12'h800);
        acc = 12'h000;
        for (int i = 1; i < 16; i++) begin
            fetch_addr = 4'(i);
            #1;
            acc = acc | fetch_instr;
        end
        chk("r_w1_15", acc, 12'h000);

        // async reset in the middle of a load
        @(negedge clk);
        start(4'd3);
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        nib_valid = 1'b0;
        chk("m_w0_before", dut.mem[0], 12'h123);
        chk("m_busy_before", {11'd0, load_busy}, 12'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("m_ready", {11'd0, nib_ready}, 12'd0);
        chk("m_busy", {11'd0, load_busy}, 12'd0);
        chk("m_run", {11'd0, core_run}, 12'd0);
        fetch_chk("m_park_pc5", 4'd5, 12'h00B);
        acc = 12'h000;
        for (int i = 0; i < 16; i++) acc = acc | dut.mem[i];
        chk("m_cleared", acc, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h5);
        send(4'h5);
        nib_valid = 1'b0;
        chk("m_idle_busy", {11'd0, load_busy}, 12'd0);
        chk("m_idle_run", {11'd0, core_run}, 12'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e15_prog_loader.md
Name: e15_prog_loader

Overview:
- Upstream neighbour of the E15 core: owns the 16 x 12-bit instruction store the core fetches from.
- Loads a program from a 4-bit nibble stream over a valid/ready handshake.
- While not in RUN, it feeds the core a self-parking jump so the core's pc settles at 0.
- When the load completes, it switches the fetch port to the loaded program.

Parameters:
- WORDS, 16, instruction store depth. Fixed at 16 to match the core's 4-bit pc.
- IW, 12, instruction width: opcode[11:8], src[7:6], dst[5:4], imm[3:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle pulse; begins a load of load_len+1 words.
- load_len  input  4  last word index to load (0..15), sampled with load_start.
- nib_valid  input  1  nibble on nib_data is valid.
- nib_data  input  4  instruction nibble, most-significant nibble of each word first.
- nib_ready  output  1  loader accepts a nibble this cycle.
- fetch_addr  input  4  core pc.
- fetch_instr  output  12  instruction presented to the core (combinational).
- core_run  output  1  high when the core executes loaded code.
- load_busy  output  1  high in LOAD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all 16 store words = 12'h000.
  - nibble counter=0, word address=0, last=0, assembly register=0.
  - nib_ready=0, core_run=0, load_busy=0.
- States: IDLE, LOAD, RUN.
  - IDLE: load_start -> LOAD. Otherwise stay.
  - LOAD: after the final nibble of word `last` is accepted -> RUN.
  - RUN: load_start -> LOAD (reload). Otherwise stay.
- Entering LOAD (the clock edge on which load_start is seen in IDLE or RUN):
  - last <= load_len; address <= 0; nibble counter <= 0.
  - All 16 store words cleared to 12'h000 on the same edge.
  - load_start while already in LOAD is ignored.
- Handshake:
  - nib_ready = (state==LOAD). A transfer occurs on a clk edge when nib_valid && nib_ready.
  - Nibble counter goes 0->1->2->0. Nibbles 0 and 1 go to the assembly register as bits [11:8] and [7:4].
  - On nibble 2, store[address] <= {asm[11:4], nib_data} on the same edge. Address then increments.
  - If address==last at that point, state <= RUN on that edge; core_run is high the next cycle.
  - nib_valid low stalls indefinitely with no timeout. nib_valid outside LOAD is ignored.
- Fetch port:
  - RUN: fetch_instr = store[fetch_addr], zero-latency combinational read.
  - IDLE/LOAD: fetch_instr = {4'b0000, 2'b00, 2'b00, (~fetch_addr + 1) mod 16}. This is jmp with imm = -pc, which drives the core pc to 0 in one cycle. At pc=0 it yields 12'h000 (jmp +0) and holds there.
  - Consequence: on entering RUN the core begins at pc=0 with no core reset needed.
- Boundaries:
  - load_len=15 fills all 16 words. Address wraps to 0 after word 15; the value is unused because the state leaves LOAD.
  - Words above `last` remain 12'h000. Executing one parks the core (jmp +0).
  - A reload from RUN drops core_run on the edge that sees load_start; parking starts the next cycle.
  - rst_n asserted mid-LOAD: partial program discarded, store zeroed, state IDLE immediately (asynchronous).
  - load_start coincident with a nibble transfer in RUN: the nibble is ignored (nib_ready was 0).
- Latency:
  - Load time = 3*(load_len+1) accepted nibbles.
  - RUN is entered on the edge of the last transfer.

Test Plan:
- Reset, then fetch_addr=5 -> fetch_instr=12'h00B; fetch_addr=0 -> 12'h000; nib_ready=0, core_run=0.
- load_start with load_len=1; stream 9,1,3 then B,0,2 with nib_valid held high:
  - store[0]=12'h913 and store[1]=12'hB02.
  - core_run rises the cycle after the 6th transfer.
  - fetch_addr=0 -> 12'h913; fetch_addr=7 -> 12'h000.
- Same load with nib_valid toggling 1/0 every cycle -> identical store contents; completion after 6 transfers (11 cycles); no nibble is lost or duplicated.
- load_len=15 with 48 nibbles of pattern word i = {i, i, i} -> store[i]=12'hiii for i=0..15.
  - core_run=1 after the 48th transfer; further nib_valid is ignored.
- In RUN, pulse load_start with load_len=0:
  - core_run falls; fetch_addr=3 -> 12'h00D; store[1..15]=0.
  - Loading 8,0,0 gives store[0]=12'h800 and core_run=1.
- rst_n pulled low after 4 nibbles of a load -> outputs at reset values immediately; store all zero; state IDLE.
